// File: rtl/serial_rx_port_if.sv
// CPU/line-side bundle for the serial receive port.
// Combinational read path; no handshaking beyond the one-clk read strobe.
// No backpressure: the port side is the slave and never stalls the CPU.
interface serial_rx_port_if;
    logic       rxd;
    logic [7:0] Address;
    logic       re;
    logic [7:0] RData;
    logic       rx_nempty;

    modport master (
        output rxd,
        output Address,
        output re,
        input  RData,
        input  rx_nempty
    );

    modport slave (
        input  rxd,
        input  Address,
        input  re,
        output RData,
        output rx_nempty
    );
endinterface

// File: rtl/serial_rx_port.sv
// 8N1 UART receiver with a 4-deep byte FIFO and memory-mapped data/status regs.
// Latency: byte visible one clk after the stop-bit sample; reads are combinational.
// No backpressure: a byte arriving at a full FIFO is dropped and flags overrun.
module serial_rx_port #(
    parameter int         CLK_HZ    = 50000000,
    parameter int         BAUD      = 115200,
    parameter logic [7:0] RX_ADDR   = 8'hFE,
    parameter logic [7:0] STAT_ADDR = 8'hFD
) (
    input logic             clk,
    input logic             iRST_N,
    serial_rx_port_if.slave bus
);
    localparam int CPB  = CLK_HZ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic          rx_s1, rx_sync, rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          cnt_clr, cnt_inc, bit_take, push, ferr_set;

    logic [7:0]    mem [4];
    logic [1:0]    wr_ptr, rd_ptr;
    logic [2:0]    count;
    logic          ovr, ferr;
    logic          nempty, full, pop, stat_rd, do_write, ovr_set;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge iRST_N) begin
        if (!iRST_N) begin
            rx_s1   <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= bus.rxd;
            rx_sync <= rx_s1;
            rx_prev <= rx_sync;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge iRST_N) begin
        if (!iRST_N) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state and datapath strobes; start bit is qualified at mid-bit.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        bit_take  = 1'b0;
        push      = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_sync && rx_prev) state_nxt = START;
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rx_sync ? IDLE : DATA;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DATA: begin
                if (cnt == CPB_M1) begin
                    cnt_clr  = 1'b1;
                    bit_take = 1'b1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            STOP: begin
                if (cnt == CPB_M1) begin
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                    if (rx_sync) push     = 1'b1;
                    else         ferr_set = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit-period counter, bit index and LSB-first shift register.
    always_ff @(posedge clk or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
            if (state != DATA) bit_idx <= 3'd0;
            else if (bit_take) bit_idx <= bit_idx + 3'd1;
            if (bit_take) shift[bit_idx] <= rx_sync;
        end
    end

    assign nempty   = (count != 3'd0);
    assign full     = (count == 3'd4);
    assign pop      = bus.re && (bus.Address == RX_ADDR) && nempty;
    assign stat_rd  = bus.re && (bus.Address == STAT_ADDR);
    // At full a concurrent pop frees the head slot, which is where wr_ptr points.
    assign do_write = push && (!full || pop);
    assign ovr_set  = push && full && !pop;

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= shift;
    end

    // FIFO pointers/occupancy and sticky error flags (new events beat a clear).
    always_ff @(posedge clk or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
            ovr    <= 1'b0;
            ferr   <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 2'd1;
            if (pop)      rd_ptr <= rd_ptr + 2'd1;
            if (do_write && !pop)      count <= count + 3'd1;
            else if (pop && !do_write) count <= count - 3'd1;
            ovr  <= ovr_set  || (ovr  && !stat_rd);
            ferr <= ferr_set || (ferr && !stat_rd);
        end
    end

    // Combinational register read mux.
    always_comb begin
        bus.RData = 8'h00;
        if (bus.Address == RX_ADDR) begin
            if (nempty) bus.RData = mem[rd_ptr];
        end else if (bus.Address == STAT_ADDR) begin
            bus.RData = {4'b0000, ovr, ferr, full, nempty};
        end
    end

    assign bus.rx_nempty = nempty;
endmodule

// File: tb/tb_serial_rx_port.sv
// Directed bench for serial_rx_port at CPB=16.
// Frames are driven bit-by-bit on negedges; outputs checked #1 after negedge.
// Reads are single-clk strobes; the CPU side never stalls the port.
module tb_serial_rx_port;
    localparam int         CPB       = 16;
    localparam int         HALF      = CPB / 2;
    localparam logic [7:0] RX_ADDR   = 8'hFE;
    localparam logic [7:0] STAT_ADDR = 8'hFD;
    // Posedge index (counted from the first edge after the start bit falls)
    // at which the stop bit is sampled: 2 sync + 1 detect + HALF + 9 bit times.
    localparam int         PUSH_EDGE = 3 + HALF + 9 * CPB;

    logic clk;
    logic iRST_N;
    int   n_tests;
    int   n_fail;

    serial_rx_port_if bus ();

    serial_rx_port #(
        .CLK_HZ    (1600),
        .BAUD      (100),
        .RX_ADDR   (RX_ADDR),
        .STAT_ADDR (STAT_ADDR)
    ) dut (
        .clk    (clk),
        .iRST_N (iRST_N),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        bus.rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        bus.rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic peek(input logic [7:0] addr, output logic [7:0] val);
        bus.Address = addr;
        #1;
        val = bus.RData;
        bus.Address = RX_ADDR;
        #1;
    endtask

    task automatic strobe(input logic [7:0] addr);
        bus.Address = addr;
        bus.re = 1'b1;
        @(negedge clk);
        bus.re = 1'b0;
        bus.Address = RX_ADDR;
        #1;
    endtask

    logic [7:0] v;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.rxd = 1'b1;
        bus.re = 1'b0;
        bus.Address = RX_ADDR;
        iRST_N = 1'b0;

        // Reset state
        #1;
        check8("rst_nempty", {7'd0, bus.rx_nempty}, 8'h00);
        check8("rst_rdata", bus.RData, 8'h00);
        peek(STAT_ADDR, v);
        check8("rst_status", v, 8'h00);
        repeat (3) @(negedge clk);
        iRST_N = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte receive and pop
        send_frame(8'hA5, 1'b1);
        #1;
        check8("a5_nempty", {7'd0, bus.rx_nempty}, 8'h01);
        check8("a5_data", bus.RData, 8'hA5);
        strobe(RX_ADDR);
        check8("a5_pop_nempty", {7'd0, bus.rx_nempty}, 8'h00);
        check8("a5_pop_rdata", bus.RData, 8'h00);

        // Overrun: five bytes into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        peek(STAT_ADDR, v);
        check8("ovr_status", v, 8'h0B);
        for (int i = 1; i <= 4; i++) begin
            check8("ovr_data", bus.RData, 8'(i));
            strobe(RX_ADDR);
        end
        check8("ovr_drained", {7'd0, bus.rx_nempty}, 8'h00);
        peek(STAT_ADDR, v);
        check8("ovr_status_empty", v, 8'h08);
        strobe(STAT_ADDR);
        peek(STAT_ADDR, v);
        check8("ovr_status_clr", v, 8'h00);

        // Framing error: stop bit low
        send_frame(8'h3C, 1'b0);
        peek(STAT_ADDR, v);
        check8("ferr_status", v, 8'h04);
        check8("ferr_nempty", {7'd0, bus.rx_nempty}, 8'h00);
        strobe(STAT_ADDR);
        peek(STAT_ADDR, v);
        check8("ferr_clr", v, 8'h00);

        // Glitch rejection: 3-clk low pulse
        bus.rxd = 1'b0;
        repeat (3) @(negedge clk);
        bus.rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        #1;
        check8("glitch_nempty", {7'd0, bus.rx_nempty}, 8'h00);
        peek(STAT_ADDR, v);
        check8("glitch_status", v, 8'h00);
        send_frame(8'h5A, 1'b1);
        check8("glitch_next", bus.RData, 8'h5A);
        strobe(RX_ADDR);

        // Full FIFO with pop landing on the push edge
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        peek(STAT_ADDR, v);
        check8("full_status", v, 8'h03);
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (PUSH_EDGE - 1) @(negedge clk);
                #1;
                check8("prepush_head", bus.RData, 8'h11);
                bus.re = 1'b1;
                @(negedge clk);
                bus.re = 1'b0;
                #1;
                check8("simul_head", bus.RData, 8'h22);
            end
        join
        peek(STAT_ADDR, v);
        check8("simul_status", v, 8'h03);
        check8("simul_d0", bus.RData, 8'h22);
        strobe(RX_ADDR);
        check8("simul_d1", bus.RData, 8'h33);
        strobe(RX_ADDR);
        check8("simul_d2", bus.RData, 8'h44);
        strobe(RX_ADDR);
        check8("simul_d3", bus.RData, 8'h77);
        strobe(RX_ADDR);
        check8("simul_empty", {7'd0, bus.rx_nempty}, 8'h00);

        // Reset during bit 4 of a frame, with a byte already queued
        send_frame(8'h99, 1'b1);
        check8("prerst_data", bus.RData, 8'h99);
        bus.rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rxd = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        bus.rxd = 1'b0;
        repeat (HALF) @(negedge clk);
        iRST_N = 1'b0;
        #1;
        check8("midrst_nempty", {7'd0, bus.rx_nempty}, 8'h00);
        check8("midrst_rdata", bus.RData, 8'h00);
        @(negedge clk);
        bus.rxd = 1'b1;
        @(negedge clk);
        iRST_N = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        #1;
        check8("postrst_nempty", {7'd0, bus.rx_nempty}, 8'h00);
        peek(STAT_ADDR, v);
        check8("postrst_status", v, 8'h00);
        send_frame(8'hC3, 1'b1);
        check8("postrst_data", bus.RData, 8'hC3);
        strobe(RX_ADDR);
        check8("postrst_empty", {7'd0, bus.rx_nempty}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
